nanci_pe: RTL and testbench

//  One processing element of the Nanci sqrt(N) x sqrt(N) mesh sorter.

---
 rtl/nanci_pe_pkg.sv | 36 +++
 rtl/nanci_cmp_exch.sv | 57 +++++
 rtl/nanci_pe.sv | 167 ++++++++++++++++
 tb/tb_nanci_pe.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/nanci_pe_pkg.sv
// Shared definitions for the Nanci mesh-sorter processing element.
//   state_t            : phase of a PE (LOAD, SORT, COMPUTE, DONE)
//   row_keeps_min()    : whether a row compare-exchange keeps the smaller key
//   elem_key()/elem_val(): field slicing of a {key,val} element, given its widths
package nanci_pe_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    SORT    = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Widest element the helpers below accept; real elements are zero-extended into it.
  localparam int ELEM_MAX_W = 64;

  // Snake order runs left-to-right on even rows and right-to-left on odd rows.
  // The PE that comes first in snake order keeps the smaller key. On an even row
  // that is the PE whose partner is on its right; on an odd row it is the PE
  // whose partner is on its left.
  function automatic logic row_keeps_min(input logic row_odd, input logic partner_is_right);
    return partner_is_right ^ row_odd;
  endfunction

  // Key occupies the upper bits of an element, val the lower data_width bits.
  function automatic logic [ELEM_MAX_W-1:0] elem_key(input logic [ELEM_MAX_W-1:0] elem,
                                                     input int data_width);
    return elem >> data_width;
  endfunction

  function automatic logic [ELEM_MAX_W-1:0] elem_val(input logic [ELEM_MAX_W-1:0] elem,
                                                     input int data_width);
    return elem & ~({ELEM_MAX_W{1'b1}} << data_width);
  endfunction

endpackage

// File: rtl/nanci_cmp_exch.sv
// Compare-exchange selector for one side of a mesh compare-exchange.
// Ports:
//   own           in  W  this PE's current element {key,val}
//   partner       in  W  the partner PE's element {key,val}
//   partner_valid in  1  partner exists; when low the own element is returned
//   keep_min      in  1  1: keep the smaller key, 0: keep the larger key
//   result        out W  the element this PE holds after the exchange
module nanci_cmp_exch
  import nanci_pe_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 3
) (
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] own,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] partner,
  input  logic                             partner_valid,
  input  logic                             keep_min,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0] result
);

  localparam int W = ADDR_WIDTH + DATA_WIDTH;

  logic [ELEM_MAX_W-1:0] own_wide;
  logic [ELEM_MAX_W-1:0] partner_wide;
  logic [ADDR_WIDTH-1:0] own_key;
  logic [ADDR_WIDTH-1:0] partner_key;
  logic [ELEM_MAX_W-1:0] own_key_wide;
  logic [ELEM_MAX_W-1:0] partner_key_wide;
  logic                  take_partner;

  assign own_wide         = ELEM_MAX_W'(own);
  assign partner_wide     = ELEM_MAX_W'(partner);
  assign own_key_wide     = elem_key(own_wide, DATA_WIDTH);
  assign partner_key_wide = elem_key(partner_wide, DATA_WIDTH);
  assign own_key          = own_key_wide[ADDR_WIDTH-1:0];
  assign partner_key      = partner_key_wide[ADDR_WIDTH-1:0];

  // Strict comparisons so that equal keys leave the own element in place.
  always_comb begin
    take_partner = 1'b0;
    if (partner_valid) begin
      if (keep_min)
        take_partner = (partner_key < own_key);
      else
        take_partner = (partner_key > own_key);
    end
  end

  assign result = take_partner ? partner : own;

  // Upper bits of the widened copies carry nothing; fold them in so no bit is dangling.
  logic unused_bits;
  assign unused_bits = ^{own_wide[ELEM_MAX_W-1:W], partner_wide[ELEM_MAX_W-1:W],
                         own_key_wide[ELEM_MAX_W-1:ADDR_WIDTH],
                         partner_key_wide[ELEM_MAX_W-1:ADDR_WIDTH]};

endmodule

// File: rtl/nanci_pe.sv
// One processing element of the Nanci sqrt(N) x sqrt(N) mesh sorter.
// After reset it loads {rst_memory, I}, shearsorts that element by key with its
// four mesh neighbours, writes val into a local table at address key during the
// compute phase, and then holds its element forever.
// Ports (W = ADDR_WIDTH+DATA_WIDTH):
//   clk         in  1           rising-edge clock
//   rst         in  1           asynchronous active-low reset
//   rst_memory  in  ADDR_WIDTH  key captured in the LOAD phase
//   i_PE_l/r/u/d in W           left/right/upper/lower neighbour elements
//   o_PE        out W           this PE's element register {key,val}
module nanci_pe
  import nanci_pe_pkg::*;
#(
  parameter int     N              = 16,
  parameter int     SQRT_N         = 2,
  parameter int     I              = 0,
  parameter string  FILENAME       = "pe.data",
  parameter int     ADDR_WIDTH     = 3,
  parameter int     DATA_WIDTH     = 3,
  parameter int     SORT_CYCLES    = 1,
  parameter int     FIRST_IN_ROW   = 0,
  parameter logic [ADDR_WIDTH+DATA_WIDTH-1:0] MAX_INT = '1,
  parameter int     COMPUTE_CYCLES = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            rst_memory,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE_l,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE_r,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE_u,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE_d,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0] o_PE
);

  localparam int W       = ADDR_WIDTH + DATA_WIDTH;
  localparam int SIDE    = 1 << SQRT_N;
  localparam int ROW     = (I >> SQRT_N) % SIDE;
  localparam int COL     = I & (SIDE - 1);
  localparam int MAX_CYC = (SORT_CYCLES > COMPUTE_CYCLES) ? SORT_CYCLES : COMPUTE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1) + 1;

  localparam bit ROW_ODD = (ROW % 2) == 1;
  localparam bit COL_ODD = (COL % 2) == 1;

  // Edges of the mesh have no partner in that direction; a 1x1 mesh has none at all.
  localparam bit HAS_L = (SIDE > 1) && (COL != 0) && (FIRST_IN_ROW == 0);
  localparam bit HAS_R = (SIDE > 1) && (COL != SIDE - 1);
  localparam bit HAS_U = (SIDE > 1) && (ROW != 0);
  localparam bit HAS_D = (SIDE > 1) && (ROW != SIDE - 1);

  localparam logic [DATA_WIDTH-1:0] OWN_VAL  = DATA_WIDTH'(I);
  localparam logic [CNT_W-1:0]      SORT_LAST = CNT_W'(SORT_CYCLES - 1);
  localparam logic [CNT_W-1:0]      COMP_LAST = CNT_W'(COMPUTE_CYCLES - 1);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [W-1:0]          elem;
  logic [DATA_WIDTH-1:0] lut [2**ADDR_WIDTH];

  logic [CNT_W-1:0] blk;
  logic             col_step;
  logic             step_t;
  logic [W-1:0]     partner;
  logic             partner_ok;
  logic             keep_min;
  logic [W-1:0]     exch_result;

  assign o_PE = elem;

  // Step k alternates blocks of SIDE row steps and SIDE column steps; within a
  // block the pairing parity flips every step (odd-even transposition).
  assign blk      = cnt >> SQRT_N;
  assign col_step = blk[0];
  assign step_t   = cnt[0];

  // Pick the partner for this step and whether this PE keeps the smaller key.
  always_comb begin
    partner    = MAX_INT;
    partner_ok = 1'b0;
    keep_min   = 1'b0;
    if (!col_step) begin
      if (COL_ODD == step_t) begin
        partner    = i_PE_r;
        partner_ok = HAS_R;
        keep_min   = row_keeps_min(ROW_ODD, 1'b1);
      end else begin
        partner    = i_PE_l;
        partner_ok = HAS_L;
        keep_min   = row_keeps_min(ROW_ODD, 1'b0);
      end
    end else begin
      if (ROW_ODD == step_t) begin
        partner    = i_PE_d;
        partner_ok = HAS_D;
        keep_min   = 1'b1;
      end else begin
        partner    = i_PE_u;
        partner_ok = HAS_U;
        keep_min   = 1'b0;
      end
    end
  end

  nanci_cmp_exch #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cmp_exch (
    .own           (elem),
    .partner       (partner),
    .partner_valid (partner_ok),
    .keep_min      (keep_min),
    .result        (exch_result)
  );

  // Phase sequencer and element register. Reset aborts any phase back to LOAD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LOAD;
      cnt   <= '0;
      elem  <= MAX_INT;
    end else begin
      case (state)
        LOAD: begin
          elem  <= {rst_memory, OWN_VAL};
          cnt   <= '0;
          state <= SORT;
        end
        SORT: begin
          elem <= exch_result;
          if (cnt == SORT_LAST) begin
            cnt   <= '0;
            state <= COMPUTE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        COMPUTE: begin
          if (cnt == COMP_LAST) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

  // Local table: no reset, so writes from an aborted run survive a later reset.
  always_ff @(posedge clk) begin
    if (state == COMPUTE)
      lut[elem[W-1:DATA_WIDTH]] <= elem[DATA_WIDTH-1:0];
  end

  // Mesh size and the table image name describe the surrounding array only.
  localparam int    MESH_N    = N;
  localparam string INIT_FILE = FILENAME;
  logic unused_cfg;
  assign unused_cfg = (MESH_N < 0) || (INIT_FILE == "");

endmodule

// File: tb/tb_nanci_pe.sv
module tb_nanci_pe;

  logic clk;
  logic rst;

  int assertCount = 0;
  int failCount   = 0;

  localparam logic [5:0] MAXV = 6'b111111;

  // Single-PE (1x1 mesh) instances: no partner ever exists.
  logic [2:0] mem_a;
  logic [5:0] nb_l, nb_r, nb_u, nb_d;
  logic [5:0] o_a, o_b;

  // Row-step PEs in a 2x2 mesh, one sort step only.
  logic [5:0] row_r;
  logic [5:0] o_re, o_ro;

  // Full 2x2 mesh.
  logic [5:0] m0, m1, m2, m3;

  nanci_pe #(.N(1), .SQRT_N(0), .I(5), .ADDR_WIDTH(3), .DATA_WIDTH(3),
             .SORT_CYCLES(1), .COMPUTE_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .rst_memory(mem_a),
    .i_PE_l(nb_l), .i_PE_r(nb_r), .i_PE_u(nb_u), .i_PE_d(nb_d), .o_PE(o_a));

  nanci_pe #(.N(1), .SQRT_N(0), .I(6), .ADDR_WIDTH(3), .DATA_WIDTH(3),
             .SORT_CYCLES(1), .COMPUTE_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .rst_memory(3'b010),
    .i_PE_l(nb_l), .i_PE_r(nb_r), .i_PE_u(nb_u), .i_PE_d(nb_d), .o_PE(o_b));

  nanci_pe #(.N(4), .SQRT_N(1), .I(0), .ADDR_WIDTH(3), .DATA_WIDTH(3),
             .SORT_CYCLES(1), .COMPUTE_CYCLES(1), .FIRST_IN_ROW(1)) dut_row_even (
    .clk(clk), .rst(rst), .rst_memory(3'd2),
    .i_PE_l(MAXV), .i_PE_r(row_r), .i_PE_u(MAXV), .i_PE_d(MAXV), .o_PE(o_re));

  nanci_pe #(.N(4), .SQRT_N(1), .I(2), .ADDR_WIDTH(3), .DATA_WIDTH(3),
             .SORT_CYCLES(1), .COMPUTE_CYCLES(1), .FIRST_IN_ROW(1)) dut_row_odd (
    .clk(clk), .rst(rst), .rst_memory(3'd2),
    .i_PE_l(MAXV), .i_PE_r(row_r), .i_PE_u(MAXV), .i_PE_d(MAXV), .o_PE(o_ro));

  // Mesh: PE0 row0col0, PE1 row0col1, PE2 row1col0, PE3 row1col1; keys 3,1,2,0.
  // Five steps: row, row, column, column, and a closing row pass.
  nanci_pe #(.N(4), .SQRT_N(1), .I(0), .ADDR_WIDTH(3), .DATA_WIDTH(3),
             .SORT_CYCLES(5), .COMPUTE_CYCLES(1), .FIRST_IN_ROW(1)) pe0 (
    .clk(clk), .rst(rst), .rst_memory(3'd3),
    .i_PE_l(MAXV), .i_PE_r(m1), .i_PE_u(MAXV), .i_PE_d(m2), .o_PE(m0));

  nanci_pe #(.N(4), .SQRT_N(1), .I(1), .ADDR_WIDTH(3), .DATA_WIDTH(3),
             .SORT_CYCLES(5), .COMPUTE_CYCLES(1), .FIRST_IN_ROW(0)) pe1 (
    .clk(clk), .rst(rst), .rst_memory(3'd1),
    .i_PE_l(m0), .i_PE_r(MAXV), .i_PE_u(MAXV), .i_PE_d(m3), .o_PE(m1));

  nanci_pe #(.N(4), .SQRT_N(1), .I(2), .ADDR_WIDTH(3), .DATA_WIDTH(3),
             .SORT_CYCLES(5), .COMPUTE_CYCLES(1), .FIRST_IN_ROW(1)) pe2 (
    .clk(clk), .rst(rst), .rst_memory(3'd2),
    .i_PE_l(MAXV), .i_PE_r(m3), .i_PE_u(m0), .i_PE_d(MAXV), .o_PE(m2));

  nanci_pe #(.N(4), .SQRT_N(1), .I(3), .ADDR_WIDTH(3), .DATA_WIDTH(3),
             .SORT_CYCLES(5), .COMPUTE_CYCLES(1), .FIRST_IN_ROW(0)) pe3 (
    .clk(clk), .rst(rst), .rst_memory(3'd0),
    .i_PE_l(m2), .i_PE_r(MAXV), .i_PE_u(m1), .i_PE_d(MAXV), .o_PE(m3));

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] mem;
    logic [5:0] l;
    logic [5:0] r;
    logic [5:0] u;
    logic [5:0] d;
    logic [5:0] expected;
  } vec_t;

  vec_t vecs[4];

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [5:0] got, input logic [5:0] expected);
    assertCount++;
    if (got !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %b, expected %b", name, got, expected);
    end
  endtask

  // Reset with one vector's inputs, check the reset value, then run to DONE.
  task automatic applyStimulus(input int idx);
    mem_a = vecs[idx].mem;
    nb_l  = vecs[idx].l;
    nb_r  = vecs[idx].r;
    nb_u  = vecs[idx].u;
    nb_d  = vecs[idx].d;
    rst   = 1'b0;
    #1;
    checkOutput($sformatf("vec%0d reset", idx), o_a, MAXV);
    @(negedge clk);
    rst = 1'b1;
    waitEdges(4);
    checkOutput($sformatf("vec%0d final", idx), o_a, vecs[idx].expected);
  endtask

  task automatic resetAndRelease();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [5:0] holdA;
  logic [5:0] lutWord;

  initial begin
    // 1x1 PE: own element {mem, 101} whatever the neighbours carry.
    vecs[0] = '{mem: 3'b000, l: 6'b001000, r: 6'b010000, u: 6'b011000, d: 6'b100000, expected: 6'b000101};
    vecs[1] = '{mem: 3'b111, l: 6'b000000, r: 6'b000000, u: 6'b000000, d: 6'b000000, expected: 6'b111101};
    vecs[2] = '{mem: 3'b010, l: 6'b111111, r: 6'b000001, u: 6'b010101, d: 6'b101010, expected: 6'b010101};
    vecs[3] = '{mem: 3'b101, l: 6'b000000, r: 6'b000000, u: 6'b000000, d: 6'b000000, expected: 6'b101101};

    rst   = 1'b0;
    mem_a = 3'b000;
    nb_l  = 6'b001000;
    nb_r  = 6'b010000;
    nb_u  = 6'b011000;
    nb_d  = 6'b100000;
    row_r = 6'b001111;

    // Held in reset: element stays MAX_INT through clocks and input changes.
    for (int i = 0; i < 3; i++) begin
      waitEdges(1);
      nb_l = nb_l ^ 6'b110011;
      nb_d = nb_d ^ 6'b001100;
      checkOutput($sformatf("hold reset %0d", i), o_a, MAXV);
    end

    for (int i = 0; i < 4; i++)
      applyStimulus(i);

    // Fresh run long enough for the 5-step mesh to finish.
    resetAndRelease();
    waitEdges(8);
    checkOutput("row even takes right", o_re, 6'b001111);
    checkOutput("row odd keeps own", o_ro, 6'b010010);
    checkOutput("dut_b element", o_b, 6'b010110);
    lutWord = {3'b000, dut_b.lut[2]};
    checkOutput("table[2] after compute", lutWord, 6'b000110);
    checkOutput("mesh pe0 key0", m0, 6'b000011);
    checkOutput("mesh pe1 key1", m1, 6'b001001);
    checkOutput("mesh pe3 key2", m3, 6'b010010);
    checkOutput("mesh pe2 key3", m2, 6'b011000);

    // Abort mid-sort, then rerun from LOAD.
    resetAndRelease();
    waitEdges(2);
    checkOutput("mesh pe0 after step0", m0, 6'b001001);
    checkOutput("mesh pe1 after step0", m1, 6'b011000);
    rst = 1'b0;
    #1;
    checkOutput("mid-sort reset pe0", m0, MAXV);
    checkOutput("mid-sort reset pe1", m1, MAXV);
    checkOutput("mid-sort reset pe2", m2, MAXV);
    checkOutput("mid-sort reset pe3", m3, MAXV);
    lutWord = {3'b000, dut_b.lut[2]};
    checkOutput("table persists over reset", lutWord, 6'b000110);
    @(negedge clk);
    rst = 1'b1;
    waitEdges(1);
    checkOutput("mesh pe0 reloaded", m0, 6'b011000);
    waitEdges(7);
    checkOutput("rerun pe0", m0, 6'b000011);
    checkOutput("rerun pe1", m1, 6'b001001);
    checkOutput("rerun pe3", m3, 6'b010010);
    checkOutput("rerun pe2", m2, 6'b011000);

    // DONE: everything holds while neighbour inputs toggle.
    holdA = {mem_a, 3'b101};
    for (int i = 0; i < 20; i++) begin
      nb_l  = 6'($urandom);
      nb_r  = 6'($urandom);
      nb_u  = 6'($urandom);
      nb_d  = 6'($urandom);
      row_r = 6'($urandom_range(0, 7));
      waitEdges(1);
      checkOutput($sformatf("done hold a %0d", i), o_a, holdA);
      checkOutput($sformatf("done hold row %0d", i), o_re, 6'b001111);
      checkOutput($sformatf("done hold pe0 %0d", i), m0, 6'b000011);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
